axil_sram_slave: RTL

AXIL_SRAM_SLAVE -- requirements
Module: axil_sram_slave

---
 rtl/axil_sram_slave.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/axil_sram_slave.sv
// rtl/axil_sram_slave.sv - AXI-lite slave over a single-port 64-bit word SRAM.
// One memory operation per cycle; contested write/read grants alternate.
module axil_sram_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_ADDR_WIDTH)-1];

  logic                      aw_held, w_held, ar_held;
  logic [MEM_ADDR_WIDTH-1:0] aw_idx, ar_idx;
  logic                      aw_oor, ar_oor;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      rd_prio;  // 1: read wins the next contested cycle

  logic aw_fire, w_fire, ar_fire;
  logic wr_elig, rd_elig, wr_grant, rd_grant;
  logic aw_oor_in, ar_oor_in;
  logic unused_inputs;

  assign s_axil_awready = !aw_held;
  assign s_axil_wready  = !w_held;
  assign s_axil_arready = !ar_held;

  assign aw_fire = s_axil_awvalid && s_axil_awready;
  assign w_fire  = s_axil_wvalid && s_axil_wready;
  assign ar_fire = s_axil_arvalid && s_axil_arready;

  // Any address bit above the memory window marks the access out of range.
  assign aw_oor_in = |(s_axil_awaddr >> (MEM_ADDR_WIDTH + 3));
  assign ar_oor_in = |(s_axil_araddr >> (MEM_ADDR_WIDTH + 3));

  assign unused_inputs = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr[2:0], s_axil_araddr[2:0]};

  always_comb begin
    wr_elig  = aw_held && w_held && !s_axil_bvalid;
    rd_elig  = ar_held && !s_axil_rvalid;
    wr_grant = wr_elig && (!rd_elig || !rd_prio);
    rd_grant = rd_elig && (!wr_elig || rd_prio);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      ar_held       <= 1'b0;
      aw_idx        <= '0;
      aw_oor        <= 1'b0;
      ar_idx        <= '0;
      ar_oor        <= 1'b0;
      w_data        <= '0;
      w_strb        <= '0;
      rd_prio       <= 1'b0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= RESP_OKAY;
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= RESP_OKAY;
      s_axil_rdata  <= '0;
    end else begin
      // Ready is low while held, so a fire never coincides with a grant.
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_idx  <= s_axil_awaddr[MEM_ADDR_WIDTH+2:3];
        aw_oor  <= aw_oor_in;
      end else if (wr_grant) begin
        aw_held <= 1'b0;
      end

      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end else if (wr_grant) begin
        w_held <= 1'b0;
      end

      if (ar_fire) begin
        ar_held <= 1'b1;
        ar_idx  <= s_axil_araddr[MEM_ADDR_WIDTH+2:3];
        ar_oor  <= ar_oor_in;
      end else if (rd_grant) begin
        ar_held <= 1'b0;
      end

      if (wr_elig && rd_elig) begin
        rd_prio <= wr_grant;
      end

      if (wr_grant) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= aw_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axil_bvalid && s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end

      if (rd_grant) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rresp  <= ar_oor ? RESP_SLVERR : RESP_OKAY;
        s_axil_rdata  <= ar_oor ? '0 : mem[ar_idx];
      end else if (s_axil_rvalid && s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

  // Memory contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_grant && !aw_oor) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (w_strb[i]) begin
          mem[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

endmodule
